// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter; the arbiter side uses the master modport.
// The timeout signal exists only when UART_TX_ARB_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_send;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_busy;
  logic                         grant_active;
  logic [ID_W-1:0]              grant_id;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic                         timeout;
`endif

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_send, tx_data, grant_active, grant_id
`ifdef UART_TX_ARB_TIMEOUT_EN
    , output timeout
`endif
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_send, tx_data, grant_active, grant_id
`ifdef UART_TX_ARB_TIMEOUT_EN
    , input timeout
`endif
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx among NUM_REQ byte streams.
// Define UART_TX_ARB_TIMEOUT_EN to release a stalled owner after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]           state_reg;
  logic [ID_W-1:0]      grant_id_reg;
  logic                 grant_active_reg;
  logic                 last_flag_reg;
  logic [ID_W-1:0]      pick_id;
  logic                 owner_valid;
  logic                 send;
  logic [DATA_BITS-1:0] req_byte [NUM_REQ];

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt_reg;
  logic               timeout_reg;
  assign bus.timeout = timeout_reg;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_byte[gi] = bus.req_data[gi*DATA_BITS +: DATA_BITS];
  end

  // Scan downward so the lowest offset past the pointer wins the final assignment.
  always_comb begin
    logic [ID_W-1:0] idx;
    pick_id = grant_id_reg;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(grant_id_reg) + k) % NUM_REQ);
      if (bus.req_valid[idx]) pick_id = idx;
    end
  end

  assign owner_valid = bus.req_valid[grant_id_reg];
  assign send        = (state_reg == ST_SEND) && owner_valid && !bus.tx_busy;

  always_comb begin
    bus.tx_send   = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    if (state_reg == ST_SEND) begin
      bus.tx_data               = req_byte[grant_id_reg];
      bus.tx_send               = send;
      bus.req_ready[grant_id_reg] = send;
    end
  end

  assign bus.grant_active = grant_active_reg;
  assign bus.grant_id     = grant_id_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      grant_active_reg <= 1'b0;
      grant_id_reg     <= ID_W'(NUM_REQ - 1);
      last_flag_reg    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_cnt_reg    <= '0;
      timeout_reg      <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_reg <= 1'b0;
      if (state_reg != ST_SEND) stall_cnt_reg <= '0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            grant_id_reg     <= pick_id;
            grant_active_reg <= 1'b1;
            state_reg        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (send) begin
            last_flag_reg <= bus.req_last[grant_id_reg];
            state_reg     <= ST_WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
            stall_cnt_reg <= '0;
          end else if (owner_valid) begin
            stall_cnt_reg <= '0;
          end else if (stall_cnt_reg == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            // Pointer stays on the stalled owner, so it ranks last next round.
            grant_active_reg <= 1'b0;
            state_reg        <= ST_IDLE;
            timeout_reg      <= 1'b1;
            stall_cnt_reg    <= '0;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
`endif
          end
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy) state_reg <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (last_flag_reg) begin
              grant_active_reg <= 1'b0;
              state_reg        <= ST_IDLE;
            end else begin
              state_reg <= ST_SEND;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level model with per-cycle output checks, a simple
// uart_tx busy model, directed scenarios and a randomized phase.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_BITS = 8;
  localparam int TIMEOUT   = 16;
  localparam int CPB       = 4;
  localparam int FRAME     = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic uart_busy  = 1'b0;
  logic force_busy = 1'b0;
  int   uart_cnt   = 0;
  assign bus.tx_busy = uart_busy | force_busy;

  // Requester queues hold {last, byte}; popped when the DUT accepts.
  logic [8:0] rq_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] gap_hold = '0;
  int  gap_cnt [NUM_REQ];
  bit  rand_gaps = 0;

  int tests = 0;
  int fails = 0;

  int obs_bytes[$];
  int obs_ids[$];
  int obs_grant[$];
  int timeout_seen = 0;
  int pushed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(int ptr, logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return ptr;
  endfunction

  // Model of ownership: who owns the transmitter, whether a byte is in flight.
  bit m_active, m_in_flight, m_seen, m_last, m_timeout_exp, prev_active;
  int m_id, m_stall;

  initial begin
    logic                         s_rst, s_busy, s_send, exp_send, in_send;
    logic [NUM_REQ-1:0]           s_valid, s_last, s_ready;
    logic [NUM_REQ*DATA_BITS-1:0] s_data;
    m_active = 0; m_in_flight = 0; m_seen = 0; m_last = 0; m_id = NUM_REQ - 1;
    m_stall = 0; m_timeout_exp = 0; prev_active = 0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_busy = bus.tx_busy; s_valid = bus.req_valid;
      s_last = bus.req_last; s_data = bus.req_data;
      s_send = bus.tx_send; s_ready = bus.req_ready;
      in_send  = m_active && !m_in_flight;
      exp_send = in_send && s_valid[m_id] && !s_busy;
      chk("grant_active", 32'(bus.grant_active), 32'(m_active));
      chk("grant_id", 32'(bus.grant_id), 32'(m_id));
      chk("tx_send", 32'(bus.tx_send), 32'(exp_send));
      chk("req_ready", 32'(bus.req_ready), exp_send ? (32'd1 << m_id) : 32'd0);
      chk("tx_data", 32'(bus.tx_data), in_send ? 32'(s_data[m_id*DATA_BITS +: DATA_BITS]) : 32'd0);
`ifdef UART_TX_ARB_TIMEOUT_EN
      chk("timeout", 32'(bus.timeout), 32'(m_timeout_exp));
      if (bus.timeout) timeout_seen++;
`endif
      if (bus.grant_active && !prev_active) obs_grant.push_back(int'(bus.grant_id));
      prev_active = bus.grant_active;

      @(posedge clk);
      #1;
      m_timeout_exp = 0;
      if (s_rst) begin
        m_active = 0; m_in_flight = 0; m_seen = 0; m_last = 0; m_id = NUM_REQ - 1; m_stall = 0;
        uart_busy = 0; uart_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
          rq_q[i].delete();
          gap_cnt[i] = 0;
        end
      end else begin
        if (s_send && !uart_busy) begin
          uart_busy = 1; uart_cnt = FRAME;
        end else if (uart_busy) begin
          uart_cnt--;
          if (uart_cnt == 0) uart_busy = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (s_ready[i] && rq_q[i].size() > 0) begin
            obs_bytes.push_back(int'(rq_q[i][0][7:0]));
            obs_ids.push_back(i);
            void'(rq_q[i].pop_front());
          end
        end
        if (!m_active) begin
          if (s_valid != '0) begin
            m_active = 1; m_id = rr_pick(m_id, s_valid); m_stall = 0;
          end
        end else if (!m_in_flight) begin
          if (exp_send) begin
            m_in_flight = 1; m_seen = 0; m_last = s_last[m_id]; m_stall = 0;
`ifdef UART_TX_ARB_TIMEOUT_EN
          end else if (!s_valid[m_id]) begin
            m_stall++;
            if (m_stall == TIMEOUT) begin
              m_active = 0; m_stall = 0; m_timeout_exp = 1;
            end
          end else begin
            m_stall = 0;
`endif
          end
        end else if (!m_seen) begin
          if (s_busy) m_seen = 1;
        end else if (!s_busy) begin
          m_in_flight = 0;
          if (m_last) m_active = 0;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      logic v;
      v = (rq_q[i].size() > 0) && (gap_cnt[i] == 0) && !gap_hold[i];
      bus.req_valid[i] = v;
      bus.req_last[i]  = v ? rq_q[i][0][8] : 1'b0;
      bus.req_data[i*DATA_BITS +: DATA_BITS] = v ? rq_q[i][0][7:0] : 8'($urandom);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gap_cnt[i] > 0) gap_cnt[i]--;
      else if (rand_gaps && $urandom_range(0, 9) == 0) gap_cnt[i] = $urandom_range(1, 4);
    end
    drive();
  endtask

  task automatic push_pkt(int r, int n, int base);
    for (int k = 0; k < n; k++) begin
      rq_q[r].push_back({(k == n - 1) ? 1'b1 : 1'b0, 8'(base + k)});
      pushed++;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic run_idle(int budget);
    int n = 0;
    while (!(all_empty() && !bus.grant_active) && n < budget) begin
      cycle(); n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_bytes(int cnt, int budget);
    int n = 0;
    while (obs_bytes.size() < cnt && n < budget) begin
      cycle(); n++;
    end
    chk("wait_bytes_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1;
    cycle(); cycle();
    rst = 0;
    obs_bytes.delete(); obs_ids.delete(); obs_grant.delete();
    pushed = 0;
  endtask

  initial begin
    int exp_ids [5];
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    for (int i = 0; i < NUM_REQ; i++) gap_cnt[i] = 0;
    do_reset();
    #4;
    chk("reset_grant_active", 32'(bus.grant_active), 32'd0);
    chk("reset_grant_id", 32'(bus.grant_id), 32'(NUM_REQ - 1));
    chk("reset_tx_send", 32'(bus.tx_send), 32'd0);
    chk("reset_tx_data", 32'(bus.tx_data), 32'd0);

    // Three-byte packet from requester 0.
    cycle();
    push_pkt(0, 3, 8'h41); drive();
    run_idle(400);
    chk("t1_count", 32'(obs_bytes.size()), 32'd3);
    chk("t1_b0", 32'(obs_bytes[0]), 32'h41);
    chk("t1_b1", 32'(obs_bytes[1]), 32'h42);
    chk("t1_b2", 32'(obs_bytes[2]), 32'h43);
    chk("t1_owner", 32'(obs_ids[2]), 32'd0);

    // All four request at once, two rounds.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 1, 8'h10 + i);
    drive();
    run_idle(600);
    for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 1, 8'h20 + i);
    drive();
    run_idle(600);
    chk("t2_grants", 32'(obs_grant.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("t2_order", 32'(obs_grant[k]), 32'(k % NUM_REQ));

    // Requester 1 arrives mid-packet of requester 2.
    do_reset();
    push_pkt(2, 4, 8'hB0); drive();
    wait_bytes(1, 200);
    push_pkt(1, 1, 8'h77); drive();
    run_idle(800);
    exp_ids = '{2, 2, 2, 2, 1};
    chk("t3_count", 32'(obs_ids.size()), 32'd5);
    for (int k = 0; k < 5; k++) chk("t3_owner", 32'(obs_ids[k]), 32'(exp_ids[k]));

    // Busy held externally while owner is valid.
    do_reset();
    force_busy = 1;
    push_pkt(3, 1, 8'h5A); drive();
    repeat (10) cycle();
    chk("t4_tx_send", 32'(bus.tx_send), 32'd0);
    chk("t4_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t4_active", 32'(bus.grant_active), 32'd1);
    chk("t4_id", 32'(bus.grant_id), 32'd3);
    chk("t4_none_sent", 32'(obs_bytes.size()), 32'd0);
    force_busy = 0;
    run_idle(200);
    chk("t4_byte", 32'(obs_bytes[0]), 32'h5A);

    // Reset during WAIT_DONE of byte 2 of 3.
    do_reset();
    push_pkt(1, 3, 8'hC0); drive();
    wait_bytes(2, 300);
    repeat (5) cycle();
    rst = 1;
    cycle();
    rst = 0;
    #4;
    chk("t5_active", 32'(bus.grant_active), 32'd0);
    chk("t5_tx_send", 32'(bus.tx_send), 32'd0);
    chk("t5_id", 32'(bus.grant_id), 32'(NUM_REQ - 1));
    obs_grant.delete();
    push_pkt(2, 1, 8'hD2);
    push_pkt(0, 1, 8'hD0);
    run_idle(400);
    chk("t5_first_grant", 32'(obs_grant[0]), 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Owner 0 stalls mid-packet; lock released to requester 1.
    do_reset();
    push_pkt(0, 3, 8'hE0); drive();
    wait_bytes(1, 200);
    gap_hold[0] = 1;
    push_pkt(1, 1, 8'hE9); drive();
    begin
      int n = 0;
      while (obs_grant.size() < 2 && n < 300) begin cycle(); n++; end
    end
    chk("t6_timeouts", 32'(timeout_seen), 32'd1);
    chk("t6_next_owner", 32'(obs_grant[1]), 32'd1);
    gap_hold[0] = 0;
    run_idle(800);
`endif

    // Randomized traffic with valid gaps and busy stalls.
    do_reset();
    rand_gaps = 1;
    for (int c = 0; c < 4000; c++) begin
      cycle();
      if ($urandom_range(0, 19) == 0) begin
        int r;
        r = $urandom_range(0, NUM_REQ - 1);
        if (rq_q[r].size() < 6) push_pkt(r, $urandom_range(1, 4), $urandom_range(0, 255));
      end
      if ($urandom_range(0, 99) == 0) force_busy = !force_busy;
      drive();
    end
    rand_gaps = 0;
    force_busy = 0;
    for (int i = 0; i < NUM_REQ; i++) gap_cnt[i] = 0;
    drive();
    run_idle(8000);
    chk("rand_all_sent", 32'(obs_bytes.size()), 32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule
